// File: rtl/ksa.sv
// ARC4 key-schedule engine driving a single-port S memory (sync read, 1-cycle latency).
// Optional build macro KSA_KEY_LATCH_EN: register the key at start and use that copy for the run.
module ksa (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren
);

  typedef enum logic [2:0] {
    IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  i, j, si, sj;
  logic [1:0]  kidx;
  logic [7:0]  kbyte;
  logic [23:0] key_use;

`ifdef KSA_KEY_LATCH_EN
  logic [23:0] key_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      key_q <= '0;
    else if (state == IDLE && en)
      key_q <= key;
  end

  assign key_use = key_q;
`else
  assign key_use = key;
`endif

  // kidx tracks i mod 3 incrementally instead of dividing i.
  always_comb begin
    kbyte = key_use[7:0];
    case (kidx)
      2'd0:    kbyte = key_use[23:16];
      2'd1:    kbyte = key_use[15:8];
      default: kbyte = key_use[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (en) begin
            i    <= '0;
            j    <= '0;
            kidx <= '0;
          end
        end
        WT_I: begin
          si <= rddata;
          j  <= j + rddata + kbyte;
        end
        WT_J: sj <= rddata;
        WR_J: begin
          if (i != 8'd255) begin
            i    <= i + 8'd1;
            kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    wren     = 1'b0;
    addr     = '0;
    wrdata   = '0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nx = RD_I;
      end
      RD_I: begin
        addr     = i;
        state_nx = WT_I;
      end
      WT_I: begin
        addr     = i;
        state_nx = RD_J;
      end
      RD_J: begin
        addr     = j;
        state_nx = WT_J;
      end
      WT_J: begin
        addr     = j;
        state_nx = WR_I;
      end
      WR_I: begin
        addr     = i;
        wrdata   = sj;
        wren     = 1'b1;
        state_nx = WR_J;
      end
      WR_J: begin
        addr     = j;
        wrdata   = si;
        wren     = 1'b1;
        state_nx = (i == 8'd255) ? DONE : RD_I;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: S memory model plus a plain software ARC4 key schedule as reference.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n, en, rdy, wren;
  logic [23:0] key;
  logic [7:0]  addr, rddata, wrdata;

  logic [7:0]  mem   [256];
  logic [7:0]  ref_s [256];
  logic [7:0]  wa[$];
  logic [7:0]  wd[$];
  int          busy;
  logic        init_req;
  int          vectors = 0;
  int          fails   = 0;

  always #5 clk = ~clk;

  ksa dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  // S memory: writes commit at the edge, read data appears the cycle after addr.
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= k[7:0];
      wa.delete();
      wd.delete();
      busy <= 0;
    end else begin
      if (!rdy) busy <= busy + 1;
      if (wren) begin
        mem[addr] <= wrdata;
        wa.push_back(addr);
        wd.push_back(wrdata);
      end
    end
    rddata <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_ksa(input logic [23:0] k, input int unsigned iters, input int unsigned runs);
    int unsigned jj;
    logic [7:0]  kb, t;
    for (int n = 0; n < 256; n++) ref_s[n] = n[7:0];
    for (int unsigned r = 0; r < runs; r++) begin
      jj = 0;
      for (int unsigned ii = 0; ii < iters; ii++) begin
        kb = (ii % 3 == 0) ? k[23:16] : (ii % 3 == 1) ? k[15:8] : k[7:0];
        jj = (jj + ref_s[ii] + kb) % 256;
        t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
      end
    end
  endtask

  task automatic check_mem(input string tag);
    for (int n = 0; n < 256; n++) check(tag, {24'd0, mem[n]}, {24'd0, ref_s[n]});
  endtask

  task automatic start_run(input logic [23:0] k);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    key = k;
    check("rdy_idle", {31'd0, rdy}, 32'd1);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("rdy_busy", {31'd0, rdy}, 32'd0);
    check("addr_rd_i0", {24'd0, addr}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!rdy && c < 4000) begin
      @(negedge clk);
      c++;
    end
    check(tag, {31'd0, rdy}, 32'd1);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int c = 0;
    while (wa.size() < n && c < 4000) begin
      @(negedge clk);
      c++;
    end
    check(tag, wa.size(), n);
  endtask

  task automatic full_run(input logic [23:0] k, input string tag);
    start_run(k);
    wait_done({tag, "_done"});
    check({tag, "_busy"}, busy, 1537);
    check({tag, "_nwr"}, wa.size(), 512);
    model_ksa(k, 256, 1);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    logic [23:0] rk;
    rst_n = 1'b0; en = 1'b0; key = '0; init_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_wrdata", {24'd0, wrdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    full_run(24'h010203, "k010203");
    check("k010203_wa0", {24'd0, wa[0]}, 32'd0);
    check("k010203_wd0", {24'd0, wd[0]}, 32'd1);
    check("k010203_wa1", {24'd0, wa[1]}, 32'd1);
    check("k010203_wd1", {24'd0, wd[1]}, 32'd0);

    full_run(24'h000000, "k0");
    check("k0_wa0", {24'd0, wa[0]}, 32'd0);
    check("k0_wd0", {24'd0, wd[0]}, 32'd0);
    check("k0_wa1", {24'd0, wa[1]}, 32'd0);
    check("k0_wd1", {24'd0, wd[1]}, 32'd0);
    check("k0_wa4", {24'd0, wa[4]}, 32'd2);
    check("k0_wd4", {24'd0, wd[4]}, 32'd3);
    check("k0_wa5", {24'd0, wa[5]}, 32'd3);
    check("k0_wd5", {24'd0, wd[5]}, 32'd2);

    full_run(24'h000311, "k000311");

    for (int r = 0; r < 3; r++) begin
      rk = 24'($urandom);
      full_run(rk, "krand");
    end

    // Abort at the start of iteration 100.
    start_run(24'h000311);
    wait_writes(200, "abort_reach");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_rdy", {31'd0, rdy}, 32'd1);
    check("abort_wren", {31'd0, wren}, 32'd0);
    check("abort_addr", {24'd0, addr}, 32'd0);
    repeat (20) @(negedge clk);
    check("abort_nowr", wa.size(), 200);
    model_ksa(24'h000311, 100, 1);
    check_mem("abort_mem");

    // Busy en pulse ignored; en held across DONE restarts at once from i=j=0.
    rk = 24'($urandom);
    start_run(rk);
    wait_writes(50, "enp_reach");
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_writes(500, "enh_reach");
    en = 1'b1;
    wait_done("enh_done1");
    check("enh_busy1", busy, 1537);
    @(negedge clk);
    en = 1'b0;
    check("enh_restart_rdy", {31'd0, rdy}, 32'd0);
    check("enh_restart_addr", {24'd0, addr}, 32'd0);
    wait_done("enh_done2");
    check("enh_nwr", wa.size(), 1024);
    model_ksa(rk, 256, 2);
    check_mem("enh_mem");

`ifdef KSA_KEY_LATCH_EN
    start_run(24'h5a3c96);
    wait_writes(300, "latch_reach");
    key = 24'h0f1e2d;
    wait_done("latch_done");
    model_ksa(24'h5a3c96, 256, 1);
    check_mem("latch_mem");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
